// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and helpers for the CPU datapath slice.
//   - N, RA_W     : default datapath width and register address width
//   - alu_ctrl_t  : ALU operation encoding
//   - src_b_sel_t : ALU operand b source select
//   - id_ex_t     : fields captured by the ID/EX pipeline register
//   - fwd_match() : true when a writing pipeline stage targets a given register
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int N    = 32;
    localparam int RA_W = 5;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_NOR = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SUB = 3'b110
    } alu_ctrl_t;

    // Encoding 11 is reserved and behaves like SRC_B_RT.
    typedef enum logic [1:0] {
        SRC_B_RT    = 2'b00,
        SRC_B_IMM   = 2'b01,
        SRC_B_SHAMT = 2'b10,
        SRC_B_RSVD  = 2'b11
    } src_b_sel_t;

    typedef struct packed {
        logic [RA_W-1:0] rs_addr;
        logic [RA_W-1:0] rt_addr;
        logic [N-1:0]    rs_data;
        logic [N-1:0]    rt_data;
        logic [N-1:0]    imm;
        logic [4:0]      shamt;
        logic            src_a_sel;
        src_b_sel_t      src_b_sel;
        alu_ctrl_t       alu_ctrl;
        logic [RA_W-1:0] rd_addr;
        logic            reg_write;
    } id_ex_t;

    // Register 0 is hardwired to zero, so it never matches a forwarding source.
    function automatic logic fwd_match(input logic            wr,
                                       input logic [RA_W-1:0] rd,
                                       input logic [RA_W-1:0] addr);
        return wr && (rd == addr) && (addr != '0);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
//   Produces the forwarded value of one source register.
//   Priority: EX/MEM result > MEM/WB result > registered data; register 0
//   always reads 0.
//   Ports:
//     addr      in   source register address
//     reg_data  in   value captured from the register file
//     exm_*     in   EX/MEM write enable, destination, result
//     mwb_*     in   MEM/WB write enable, destination, result
//     fwd_data  out  forwarded operand value
// -----------------------------------------------------------------------------
module fwd_mux #(
    parameter int N    = cpu_pkg::N,
    parameter int RA_W = cpu_pkg::RA_W
) (
    input  logic [RA_W-1:0] addr,
    input  logic [N-1:0]    reg_data,
    input  logic            exm_wr,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [N-1:0]    exm_data,
    input  logic            mwb_wr,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic [N-1:0]    mwb_data,
    output logic [N-1:0]    fwd_data
);
    import cpu_pkg::*;

    // The zero check comes first so a stale regfile value held for r0 never leaks.
    always_comb begin
        if (addr == '0) begin
            fwd_data = '0;
        end else if (fwd_match(exm_wr, exm_rd, addr)) begin
            fwd_data = exm_data;
        end else if (fwd_match(mwb_wr, mwb_rd, addr)) begin
            fwd_data = mwb_data;
        end else begin
            fwd_data = reg_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register feeding the ALU. Accepts one decoded instruction
//   per cycle over valid/ready, registers operands and control, applies
//   EX/MEM and MEM/WB forwarding, and presents a, b and ctrl to the ALU.
//   Ports:
//     clk, rst_n              clock, asynchronous active-low reset
//     id_valid / id_ready     upstream handshake (id_ready = !ex_valid || ex_ready)
//     id_*                    decoded instruction fields and regfile reads
//     flush                   kill the held and the incoming instruction
//     exm_*, mwb_*            forwarding sources from EX/MEM and MEM/WB
//     ex_valid / ex_ready     downstream handshake
//     ex_a, ex_b, ex_ctrl     ALU operands and operation
//     ex_rd_addr, ex_reg_write destination info passed through
//     stall_cnt               saturating count of backpressured cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int N      = cpu_pkg::N,
    parameter int RA_W   = cpu_pkg::RA_W,
    parameter int SCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [RA_W-1:0]   id_rs_addr,
    input  logic [RA_W-1:0]   id_rt_addr,
    input  logic [N-1:0]      id_rs_data,
    input  logic [N-1:0]      id_rt_data,
    input  logic [N-1:0]      id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_src_a_sel,
    input  logic [1:0]        id_src_b_sel,
    input  logic [2:0]        id_alu_ctrl,
    input  logic [RA_W-1:0]   id_rd_addr,
    input  logic              id_reg_write,
    input  logic              flush,
    input  logic              exm_wr,
    input  logic [RA_W-1:0]   exm_rd,
    input  logic [N-1:0]      exm_data,
    input  logic              mwb_wr,
    input  logic [RA_W-1:0]   mwb_rd,
    input  logic [N-1:0]      mwb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [N-1:0]      ex_a,
    output logic [N-1:0]      ex_b,
    output logic [2:0]        ex_ctrl,
    output logic [RA_W-1:0]   ex_rd_addr,
    output logic              ex_reg_write,
    output logic [SCNT_W-1:0] stall_cnt
);
    import cpu_pkg::*;

    id_ex_t     held;
    logic       take;
    logic       hold;
    logic [N-1:0] fwd_rs;
    logic [N-1:0] fwd_rt;

    assign id_ready = !ex_valid || ex_ready;
    assign take     = id_valid && id_ready;
    assign hold     = ex_valid && !ex_ready;

    // Pipeline register. Flush wins over everything. On capture, a MEM/WB
    // write to the same register replaces the regfile read (same-cycle
    // write/read). While held, MEM/WB results are folded into the stored data
    // so the value is still correct after that instruction has retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            held     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (take) begin
            ex_valid       <= 1'b1;
            held.rs_addr   <= id_rs_addr;
            held.rt_addr   <= id_rt_addr;
            held.rs_data   <= fwd_match(mwb_wr, mwb_rd, id_rs_addr) ? mwb_data : id_rs_data;
            held.rt_data   <= fwd_match(mwb_wr, mwb_rd, id_rt_addr) ? mwb_data : id_rt_data;
            held.imm       <= id_imm;
            held.shamt     <= id_shamt;
            held.src_a_sel <= id_src_a_sel;
            held.src_b_sel <= src_b_sel_t'(id_src_b_sel);
            held.alu_ctrl  <= alu_ctrl_t'(id_alu_ctrl);
            held.rd_addr   <= id_rd_addr;
            held.reg_write <= id_reg_write;
        end else if (hold) begin
            if (fwd_match(mwb_wr, mwb_rd, held.rs_addr)) begin
                held.rs_data <= mwb_data;
            end
            if (fwd_match(mwb_wr, mwb_rd, held.rt_addr)) begin
                held.rt_data <= mwb_data;
            end
        end else begin
            ex_valid <= 1'b0;
        end
    end

    // Backpressure counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_rs (
        .addr     (held.rs_addr),
        .reg_data (held.rs_data),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .mwb_wr   (mwb_wr),
        .mwb_rd   (mwb_rd),
        .mwb_data (mwb_data),
        .fwd_data (fwd_rs)
    );

    fwd_mux #(.N(N), .RA_W(RA_W)) u_fwd_rt (
        .addr     (held.rt_addr),
        .reg_data (held.rt_data),
        .exm_wr   (exm_wr),
        .exm_rd   (exm_rd),
        .exm_data (exm_data),
        .mwb_wr   (mwb_wr),
        .mwb_rd   (mwb_rd),
        .mwb_data (mwb_data),
        .fwd_data (fwd_rt)
    );

    // Operand selection; shifts take their value from rt on port a.
    always_comb begin
        ex_a = held.src_a_sel ? fwd_rt : fwd_rs;
        case (held.src_b_sel)
            SRC_B_IMM:   ex_b = held.imm;
            SRC_B_SHAMT: ex_b = {{(N-5){1'b0}}, held.shamt};
            default:     ex_b = fwd_rt;
        endcase
    end

    assign ex_ctrl      = held.alu_ctrl;
    assign ex_rd_addr   = held.rd_addr;
    assign ex_reg_write = held.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage: a table of directed single-cycle
//   vectors with full throughput, followed by hand-written sequences for
//   reset, hold-refresh, flush and stall-counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_shamt;
    logic        id_src_a_sel;
    logic [1:0]  id_src_b_sel;
    logic [2:0]  id_alu_ctrl;
    logic [4:0]  id_rd_addr;
    logic        id_reg_write;
    logic        flush;
    logic        exm_wr;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        mwb_wr;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [2:0]  ex_ctrl;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;
    logic [15:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [2:0]  ctrl;
        logic [4:0]  rd;
        logic        rw;
        logic        exm_wr;
        logic [4:0]  exm_rd;
        logic [31:0] exm_d;
        logic        mwb_wr;
        logic [4:0]  mwb_rd;
        logic [31:0] mwb_d;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [2:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic        e_rw;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_rs_addr   (id_rs_addr),
        .id_rt_addr   (id_rt_addr),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_shamt     (id_shamt),
        .id_src_a_sel (id_src_a_sel),
        .id_src_b_sel (id_src_b_sel),
        .id_alu_ctrl  (id_alu_ctrl),
        .id_rd_addr   (id_rd_addr),
        .id_reg_write (id_reg_write),
        .flush        (flush),
        .exm_wr       (exm_wr),
        .exm_rd       (exm_rd),
        .exm_data     (exm_data),
        .mwb_wr       (mwb_wr),
        .mwb_rd       (mwb_rd),
        .mwb_data     (mwb_data),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_ctrl      (ex_ctrl),
        .ex_rd_addr   (ex_rd_addr),
        .ex_reg_write (ex_reg_write),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_valid     = v.valid;
        id_rs_addr   = v.rs;
        id_rt_addr   = v.rt;
        id_rs_data   = v.rs_d;
        id_rt_data   = v.rt_d;
        id_imm       = v.imm;
        id_shamt     = v.shamt;
        id_src_a_sel = v.a_sel;
        id_src_b_sel = v.b_sel;
        id_alu_ctrl  = v.ctrl;
        id_rd_addr   = v.rd;
        id_reg_write = v.rw;
        exm_wr       = v.exm_wr;
        exm_rd       = v.exm_rd;
        exm_data     = v.exm_d;
        mwb_wr       = v.mwb_wr;
        mwb_rd       = v.mwb_rd;
        mwb_data     = v.mwb_d;
    endtask

    task automatic clearInputs();
        vec_t z;
        z = '{default: '0};
        applyStimulus(z);
        flush = 1'b0;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vec_t v;

        rst_n    = 1'b0;
        ex_ready = 1'b1;
        clearInputs();

        // Directed vectors, ex_ready held high so each one also replaces its predecessor.
        vecs[0] = '{default: '0, valid: 1'b1, rs: 5'd5, rt: 5'd6, rs_d: 32'd3, rt_d: 32'd4,
                    ctrl: 3'b010, rd: 5'd8, rw: 1'b1,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'd3, e_b: 32'd4, e_ctrl: 3'b010, e_rd: 5'd8, e_rw: 1'b1};
        vecs[1] = '{default: '0, valid: 1'b1, rs: 5'd7, rt: 5'd3, rs_d: 32'h1, rt_d: 32'h22,
                    ctrl: 3'b010, rd: 5'd10, rw: 1'b1,
                    exm_wr: 1'b1, exm_rd: 5'd7, exm_d: 32'hAA, mwb_wr: 1'b1, mwb_rd: 5'd7, mwb_d: 32'hBB,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'hAA, e_b: 32'h22, e_ctrl: 3'b010, e_rd: 5'd10, e_rw: 1'b1};
        vecs[2] = '{default: '0, valid: 1'b1, rs: 5'd0, rt: 5'd3, rs_d: 32'h1234, rt_d: 32'h22,
                    ctrl: 3'b010, rd: 5'd11, rw: 1'b1,
                    exm_wr: 1'b1, exm_rd: 5'd0, exm_d: 32'hAA, mwb_wr: 1'b1, mwb_rd: 5'd0, mwb_d: 32'hBB,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'h0, e_b: 32'h22, e_ctrl: 3'b010, e_rd: 5'd11, e_rw: 1'b1};
        vecs[3] = '{default: '0, valid: 1'b1, rs: 5'd4, rt: 5'd5, rs_d: 32'h10, rt_d: 32'h33,
                    ctrl: 3'b001, rd: 5'd12, rw: 1'b1,
                    exm_wr: 1'b1, exm_rd: 5'd5, exm_d: 32'h77, mwb_wr: 1'b1, mwb_rd: 5'd4, mwb_d: 32'h99,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'h99, e_b: 32'h77, e_ctrl: 3'b001, e_rd: 5'd12, e_rw: 1'b1};
        vecs[4] = '{default: '0, valid: 1'b1, rs: 5'd6, rt: 5'd7, rs_d: 32'h44, rt_d: 32'h0,
                    imm: 32'hFFFF_FFF0, b_sel: 2'b01, ctrl: 3'b110, rd: 5'd13, rw: 1'b1,
                    exm_wr: 1'b0, exm_rd: 5'd6, exm_d: 32'hEE,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'h44, e_b: 32'hFFFF_FFF0, e_ctrl: 3'b110, e_rd: 5'd13, e_rw: 1'b1};
        vecs[5] = '{default: '0, valid: 1'b1, rs: 5'd1, rt: 5'd2, rs_d: 32'h999, rt_d: 32'h1,
                    shamt: 5'd4, a_sel: 1'b1, b_sel: 2'b10, ctrl: 3'b100, rd: 5'd3, rw: 1'b1,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'h1, e_b: 32'h4, e_ctrl: 3'b100, e_rd: 5'd3, e_rw: 1'b1};
        vecs[6] = '{default: '0, valid: 1'b1, rs: 5'd2, rt: 5'd3, rs_d: 32'h7, rt_d: 32'h5A,
                    imm: 32'h123, shamt: 5'd9, b_sel: 2'b11, ctrl: 3'b101, rd: 5'd0, rw: 1'b0,
                    e_valid: 1'b1, chk_data: 1'b1, e_a: 32'h7, e_b: 32'h5A, e_ctrl: 3'b101, e_rd: 5'd0, e_rw: 1'b0};
        vecs[7] = '{default: '0, valid: 1'b0, e_valid: 1'b0, chk_data: 1'b0};

        // Reset state
        #12;
        checkOutput("reset ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("reset ex_a", ex_a, 32'd0);
        checkOutput("reset ex_b", ex_b, 32'd0);
        checkOutput("reset ex_ctrl", 32'(ex_ctrl), 32'd0);
        checkOutput("reset ex_rd_addr", 32'(ex_rd_addr), 32'd0);
        checkOutput("reset ex_reg_write", 32'(ex_reg_write), 32'd0);
        checkOutput("reset stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("reset id_ready", 32'(id_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d id_ready", i), 32'(id_ready), 32'd1);
            tick();
            checkOutput($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            if (vecs[i].chk_data) begin
                checkOutput($sformatf("v%0d ex_a", i), ex_a, vecs[i].e_a);
                checkOutput($sformatf("v%0d ex_b", i), ex_b, vecs[i].e_b);
                checkOutput($sformatf("v%0d ex_ctrl", i), 32'(ex_ctrl), 32'(vecs[i].e_ctrl));
                checkOutput($sformatf("v%0d ex_rd_addr", i), 32'(ex_rd_addr), 32'(vecs[i].e_rd));
                checkOutput($sformatf("v%0d ex_reg_write", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
            end
        end
        checkOutput("stall_cnt after full throughput", 32'(stall_cnt), 32'd0);

        // Reset mid-stream: held instruction and stall count are discarded at once.
        clearInputs();
        v = vecs[0];
        applyStimulus(v);
        ex_ready = 1'b0;
        tick();
        id_valid = 1'b0;
        tick();
        checkOutput("midrst pre ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("midrst pre stall_cnt", 32'(stall_cnt), 32'd1);
        checkOutput("midrst pre id_ready", 32'(id_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("midrst stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("midrst ex_a", ex_a, 32'd0);
        rst_n = 1'b1;
        tick();

        // Hold-refresh: MEM/WB writes rt=9 during the first held cycle only.
        clearInputs();
        ex_ready     = 1'b0;
        id_valid     = 1'b1;
        id_rs_addr   = 5'd8;
        id_rs_data   = 32'h8;
        id_rt_addr   = 5'd9;
        id_rt_data   = 32'h11;
        id_alu_ctrl  = 3'b010;
        tick();
        id_valid = 1'b0;
        mwb_wr   = 1'b1;
        mwb_rd   = 5'd9;
        mwb_data = 32'h55;
        tick();
        mwb_wr   = 1'b0;
        mwb_data = 32'h0;
        #1;
        checkOutput("refresh held ex_b", ex_b, 32'h55);
        tick();
        tick();
        ex_ready = 1'b1;
        #1;
        checkOutput("refresh ex_valid", 32'(ex_valid), 32'd1);
        checkOutput("refresh ex_b", ex_b, 32'h55);
        checkOutput("refresh ex_a", ex_a, 32'h8);
        checkOutput("refresh stall_cnt", 32'(stall_cnt), 32'd3);
        tick();
        checkOutput("refresh drained ex_valid", 32'(ex_valid), 32'd0);

        // Flush with a held instruction and an incoming one.
        clearInputs();
        v = vecs[0];
        applyStimulus(v);
        tick();
        checkOutput("flush pre ex_valid", 32'(ex_valid), 32'd1);
        v = vecs[4];
        applyStimulus(v);
        flush = 1'b1;
        #1;
        checkOutput("flush id_ready", 32'(id_ready), 32'd1);
        tick();
        checkOutput("flush ex_valid", 32'(ex_valid), 32'd0);
        flush    = 1'b0;
        id_valid = 1'b0;
        tick();
        checkOutput("flush dropped ex_valid", 32'(ex_valid), 32'd0);

        // Flush while backpressured.
        v = vecs[0];
        applyStimulus(v);
        ex_ready = 1'b0;
        tick();
        id_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush hold ex_valid", 32'(ex_valid), 32'd0);

        // Stall counter saturation.
        pulseReset();
        clearInputs();
        ex_ready = 1'b0;
        v = vecs[0];
        applyStimulus(v);
        tick();
        id_valid = 1'b0;
        repeat (65534) tick();
        checkOutput("sat stall_cnt 0xfffe", 32'(stall_cnt), 32'hFFFE);
        tick();
        checkOutput("sat stall_cnt 0xffff", 32'(stall_cnt), 32'hFFFF);
        tick();
        tick();
        checkOutput("sat stall_cnt no wrap", 32'(stall_cnt), 32'hFFFF);
        ex_ready = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
